// File: rtl/fx_alu_pkg.sv
// Shared types and sign-magnitude helpers for the sequential fixed-point ALU.
// Helpers operate on a 64-bit container so that any WIDTH up to 64 can use them.
package fx_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_SUB = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIV_RUN,
        S_DONE
    } state_e;

    localparam int MAX_WIDTH = 64;

    function automatic logic signOf(input logic [MAX_WIDTH-1:0] word, input int width);
        return word[width-1];
    endfunction

    function automatic logic [MAX_WIDTH-1:0] magOf(input logic [MAX_WIDTH-1:0] word, input int width);
        return word & ((64'd1 << (width - 1)) - 64'd1);
    endfunction

    // A zero magnitude always packs with a positive sign, so -0 can never leave the unit.
    function automatic logic [MAX_WIDTH-1:0] packSm(input logic sign,
                                                    input logic [MAX_WIDTH-1:0] mag,
                                                    input int width);
        logic [MAX_WIDTH-1:0] m;
        m = magOf(mag, width);
        return m | (64'(sign && (m != '0)) << (width - 1));
    endfunction

endpackage

// File: rtl/fx_div_iter.sv
// Iterative restoring divider: (dividend << FRAC) / divisor, one quotient bit per clock.
// done_o is high during the cycle whose closing edge performs the final iteration.
module fx_div_iter
    import fx_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [WIDTH-2:0]        dividend_i,
    input  logic [WIDTH-2:0]        divisor_i,
    output logic                    done_o,
    output logic [WIDTH-2+FRAC:0]   quotient_o
);
    localparam int MW        = WIDTH - 1;
    localparam int DIV_ITERS = WIDTH - 1 + FRAC;
    localparam int CW        = $clog2(DIV_ITERS);

    logic                 running_q;
    logic [CW-1:0]        iter_q;
    logic [MW-1:0]        rem_q;
    logic [MW-1:0]        divisor_q;
    logic [DIV_ITERS-1:0] dq_q;

    logic [MW:0]          trial;
    logic                 fits;
    logic [MW-1:0]        rem_d;

    // The remainder stays below the divisor, so the difference always fits in MW bits.
    always_comb begin
        trial = {rem_q, dq_q[DIV_ITERS-1]};
        fits  = (trial >= {1'b0, divisor_q});
        rem_d = fits ? (trial[MW-1:0] - divisor_q) : trial[MW-1:0];
    end

    assign done_o     = running_q && (iter_q == CW'(DIV_ITERS - 1));
    assign quotient_o = dq_q;

    // Dividend bits shift out of the top of dq_q while quotient bits shift in at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            iter_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            dq_q      <= '0;
        end else if (start_i) begin
            running_q <= 1'b1;
            iter_q    <= '0;
            rem_q     <= '0;
            divisor_q <= divisor_i;
            dq_q      <= {dividend_i, {FRAC{1'b0}}};
        end else if (running_q) begin
            rem_q <= rem_d;
            dq_q  <= {dq_q[DIV_ITERS-2:0], fits};
            if (done_o) begin
                running_q <= 1'b0;
            end else begin
                iter_q <= iter_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fx_alu_seq.sv
// Sequential sign-magnitude Qm.FRAC ALU (add/sub/mul/div) with start/busy/done handshake.
// Define FX_SAT_EN to clamp overflowing magnitudes to all-ones instead of wrapping.
module fx_alu_seq
    import fx_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             ovf,
    output logic             dz
);
    localparam int MW        = WIDTH - 1;
    localparam int DIV_ITERS = WIDTH - 1 + FRAC;
    localparam int PW        = 2 * MW;
`ifdef FX_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e           state_q;
    opcode_e          op_q;
    logic             aSign_q, bSign_q;
    logic [MW-1:0]    aMag_q, bMag_q;
    logic             resSign_q, resOvf_q, resDz_q;
    logic [MW-1:0]    resMag_q;
    logic [WIDTH-1:0] c_q;
    logic             ovf_q, dz_q, done_q, busy_q;

    logic             inSignA, inSignB;
    logic [MW-1:0]    inMagA, inMagB;
    logic             accept, divStart, divLast;
    logic [DIV_ITERS-1:0] quotient;

    logic             bSignEff, addSign, addOvf, mulOvf, divOvf;
    logic [MW:0]      addWide;
    logic [PW-1:0]    product;
    logic             execSign, execOvf, execDz;
    logic [MW-1:0]    execMag;
    logic             doneSign, doneOvf, doneDz;
    logic [MW-1:0]    doneMag;
    logic [WIDTH-1:0] doneC;

    function automatic logic [MW-1:0] fitMag(input logic [MW-1:0] low, input logic over);
        return (SAT_EN && over) ? '1 : low;
    endfunction

    assign inSignA = signOf(64'(a), WIDTH);
    assign inSignB = signOf(64'(b), WIDTH);
    assign inMagA  = MW'(magOf(64'(a), WIDTH));
    assign inMagB  = MW'(magOf(64'(b), WIDTH));

    // A start arriving while the done pulse is still out is dropped, as if the unit were busy.
    assign accept   = (state_q == S_IDLE) && start && !done_q;
    assign divStart = accept && (opcode_e'(opcode) == OP_DIV) && (inMagB != '0);

    fx_div_iter #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) uDiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (divStart),
        .dividend_i (inMagA),
        .divisor_i  (inMagB),
        .done_o     (divLast),
        .quotient_o (quotient)
    );

    // Single-cycle paths: add/sub share one signed-magnitude adder; div-by-zero is a constant.
    always_comb begin
        bSignEff = (op_q == OP_SUB) ? ~bSign_q : bSign_q;
        addSign  = aSign_q;
        if (aSign_q == bSignEff) begin
            addWide = {1'b0, aMag_q} + {1'b0, bMag_q};
        end else if (aMag_q >= bMag_q) begin
            addWide = {1'b0, aMag_q - bMag_q};
        end else begin
            addWide = {1'b0, bMag_q - aMag_q};
            addSign = bSignEff;
        end
        addOvf  = addWide[MW];
        product = PW'(aMag_q) * PW'(bMag_q);
        mulOvf  = |product[PW-1:MW+FRAC];

        execSign = aSign_q ^ bSign_q;
        execOvf  = 1'b0;
        execDz   = 1'b0;
        execMag  = '1;
        case (op_q)
            OP_ADD, OP_SUB: begin
                execSign = addSign;
                execOvf  = addOvf;
                execMag  = fitMag(addWide[MW-1:0], addOvf);
            end
            OP_MUL: begin
                execOvf = mulOvf;
                execMag = fitMag(product[MW+FRAC-1:FRAC], mulOvf);
            end
            default: begin
                execDz = 1'b1;
            end
        endcase
    end

    always_comb begin
        divOvf = |quotient[DIV_ITERS-1:MW];
        if (op_q == OP_DIV && !resDz_q) begin
            doneSign = aSign_q ^ bSign_q;
            doneMag  = fitMag(quotient[MW-1:0], divOvf);
            doneOvf  = divOvf;
            doneDz   = 1'b0;
        end else begin
            doneSign = resSign_q;
            doneMag  = resMag_q;
            doneOvf  = resOvf_q;
            doneDz   = resDz_q;
        end
        doneC = WIDTH'(packSm(doneSign, 64'(doneMag), WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            aSign_q   <= 1'b0;
            bSign_q   <= 1'b0;
            aMag_q    <= '0;
            bMag_q    <= '0;
            resSign_q <= 1'b0;
            resMag_q  <= '0;
            resOvf_q  <= 1'b0;
            resDz_q   <= 1'b0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= accept;
                    if (accept) begin
                        op_q    <= opcode_e'(opcode);
                        aSign_q <= inSignA;
                        bSign_q <= inSignB;
                        aMag_q  <= inMagA;
                        bMag_q  <= inMagB;
                        resDz_q <= 1'b0;
                        state_q <= divStart ? S_DIV_RUN : S_EXEC;
                    end
                end
                S_EXEC: begin
                    resSign_q <= execSign;
                    resMag_q  <= execMag;
                    resOvf_q  <= execOvf;
                    resDz_q   <= execDz;
                    state_q   <= S_DONE;
                end
                S_DIV_RUN: begin
                    if (divLast) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    c_q     <= doneC;
                    ovf_q   <= doneOvf;
                    dz_q    <= doneDz;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_fx_alu_seq.sv
// Self-checking bench for fx_alu_seq: vector table plus handshake/abort corner sequences.
// Overflow expectations follow FX_SAT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_fx_alu_seq;
    import fx_alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] c;
    logic        ovf;
    logic        dz;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expC;
        logic        expOvf;
        logic        expDz;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic        ovf;
        logic        dz;
        int          lat;
        time         t0;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQ[$];

`ifdef FX_SAT_EN
    localparam logic [31:0] ADD_OVF_C = 32'h7FFFFFFF;
    localparam logic [31:0] MUL_OVF_C = 32'h7FFFFFFF;
    localparam logic [31:0] DIV_OVF_C = 32'h7FFFFFFF;
`else
    localparam logic [31:0] ADD_OVF_C = 32'h7F000000;
    localparam logic [31:0] MUL_OVF_C = 32'h00800000;
    localparam logic [31:0] DIV_OVF_C = 32'h00000000;
`endif

    fx_alu_seq #(.WIDTH(32), .FRAC(23)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .c      (c),
        .ovf    (ovf),
        .dz     (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareVal(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Drives one command for a single cycle, records its expectation, then scrambles the inputs.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] ec, input logic eo, input logic ed, input int el);
        exp_t e;
        @(negedge clk);
        opcode = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        e.c = ec; e.ovf = eo; e.dz = ed; e.lat = el; e.t0 = $time;
        sbQ.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        opcode = 2'($urandom);
    endtask

    task automatic checkOutput(input string tag, input bit pokeInDone);
        exp_t e;
        int   waited;
        bit   busyOk;
        int   lat;
        waited = 0;
        busyOk = 1'b1;
        while (done !== 1'b1 && waited < 200) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            @(negedge clk);
            waited++;
        end
        if (sbQ.size() == 0) begin
            compareVal({tag, " scoreboard"}, 32'd0, 32'd1);
            return;
        end
        e   = sbQ.pop_front();
        lat = int'(($time - e.t0) / 10) - 1;
        compareVal({tag, " done seen"}, {31'd0, done}, 32'd1);
        compareVal({tag, " latency"}, 32'(lat), 32'(e.lat));
        compareVal({tag, " c"}, c, e.c);
        compareVal({tag, " ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
        compareVal({tag, " dz"}, {31'd0, dz}, {31'd0, e.dz});
        compareVal({tag, " busy held"}, {31'd0, busyOk & busy}, 32'd1);
        if (pokeInDone) begin
            start  = 1'b1;
            opcode = OP_ADD;
            a      = 32'h00800000;
            b      = 32'h00800000;
        end
        @(negedge clk);
        start = 1'b0;
        compareVal({tag, " done pulse"}, {31'd0, done}, 32'd0);
        compareVal({tag, " busy clear"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic noSpuriousDone(input string nm, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        compareVal(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        opcode = 2'b00;
        a      = '0;
        b      = '0;
        #2 rst_n = 1'b0;

        vecs.push_back('{OP_ADD, 32'h00C00000, 32'h80800000, 32'h00400000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_SUB, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_MUL, 32'h00C00000, 32'h81000000, 32'h81800000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_MUL, 32'h7F800000, 32'h7F800000, MUL_OVF_C,    1'b1, 1'b0, 2});
        vecs.push_back('{OP_DIV, 32'h01800000, 32'h01000000, 32'h00C00000, 1'b0, 1'b0, 55});
        vecs.push_back('{OP_DIV, 32'h80800000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 2});
        vecs.push_back('{OP_ADD, 32'h7F800000, 32'h7F800000, ADD_OVF_C,    1'b1, 1'b0, 2});
        vecs.push_back('{OP_SUB, 32'h00400000, 32'h00C00000, 32'h80800000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_ADD, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_MUL, 32'h80000000, 32'h00800000, 32'h00000000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_DIV, 32'h80C00000, 32'h00800000, 32'h80C00000, 1'b0, 1'b0, 55});
        vecs.push_back('{OP_DIV, 32'h7F800000, 32'h00000001, DIV_OVF_C,    1'b1, 1'b0, 55});
        vecs.push_back('{OP_DIV, 32'h00800000, 32'h01800000, 32'h002AAAAA, 1'b0, 1'b0, 55});
        vecs.push_back('{OP_MUL, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_ADD, 32'h80400000, 32'h80400000, 32'h80800000, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_MUL, 32'h80C00000, 32'h80C00000, 32'h01200000, 1'b0, 1'b0, 2});

        repeat (2) @(negedge clk);
        compareVal("reset c", c, 32'd0);
        compareVal("reset ovf", {31'd0, ovf}, 32'd0);
        compareVal("reset dz", {31'd0, dz}, 32'd0);
        compareVal("reset done", {31'd0, done}, 32'd0);
        compareVal("reset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expC,
                          vecs[i].expOvf, vecs[i].expDz, vecs[i].expLat);
            checkOutput($sformatf("vec%0d", i), 1'b0);
        end

        // A start pulse in the middle of a division must be dropped, not queued.
        applyStimulus(OP_DIV, 32'h01800000, 32'h01000000, 32'h00C00000, 1'b0, 1'b0, 55);
        repeat (10) @(negedge clk);
        start  = 1'b1;
        opcode = OP_ADD;
        a      = 32'h00800000;
        b      = 32'h00800000;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy-inject", 1'b0);
        noSpuriousDone("no queued start", 6);

        // Start raised exactly in the done cycle is ignored.
        applyStimulus(OP_MUL, 32'h00C00000, 32'h81000000, 32'h81800000, 1'b0, 1'b0, 2);
        checkOutput("done-poke", 1'b1);
        noSpuriousDone("done-cycle start ignored", 6);

        // Reset in the middle of a division aborts it without a done pulse.
        applyStimulus(OP_DIV, 32'h80C00000, 32'h00800000, 32'h80C00000, 1'b0, 1'b0, 55);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        compareVal("abort c", c, 32'd0);
        compareVal("abort ovf", {31'd0, ovf}, 32'd0);
        compareVal("abort dz", {31'd0, dz}, 32'd0);
        compareVal("abort done", {31'd0, done}, 32'd0);
        compareVal("abort busy", {31'd0, busy}, 32'd0);
        void'(sbQ.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        noSpuriousDone("no done after abort", 60);

        applyStimulus(OP_DIV, 32'h01800000, 32'h01000000, 32'h00C00000, 1'b0, 1'b0, 55);
        checkOutput("post-abort div", 1'b0);
        applyStimulus(OP_ADD, 32'h00C00000, 32'h80800000, 32'h00400000, 1'b0, 1'b0, 2);
        checkOutput("post-abort add", 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
